// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the word-only data memory.
// It also turns byte-lane writes into read-modify-write sequences.
module dm_arbiter #(
  parameter int ADDR_W = 12,
  parameter int RMW_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // port A (CPU)
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [3:0]        a_be,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  output logic [31:0]       a_rdata,
  // port B (DMA/debug)
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [3:0]        b_be,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  // status
  output logic              busy,
  // memory side
  output logic [ADDR_W-3:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_wen,
  input  logic [31:0]       dm_dout
);

  typedef enum logic [1:0] {IDLE, EXEC, WRBACK, DONE} state_t;

  localparam logic RMW_ON = (RMW_EN != 0);

  state_t            state_q, state_d;
  logic              port_q;      // 0 = A, 1 = B
  logic              we_q;
  logic [ADDR_W-3:0] waddr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       merge_d;
  logic              last_b_q;    // 1 = B was granted last, so A wins a tie
  logic              grant_b;
  logic              partial;

  // The byte-offset bits carry no information: lanes come from the byte enables.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{a_addr[1:0], b_addr[1:0]};

  // Round-robin choice: B wins only when alone or when A was served last.
  assign grant_b = b_req && (!a_req || !last_b_q);
  assign partial = (be_q != 4'h0) && (be_q != 4'hF);

  // Lane merge of the new write data over the current memory word.
  always_comb begin
    merge_d = dm_dout;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merge_d[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: assign every output a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (a_req || b_req) state_d = EXEC;
      EXEC:    state_d = (we_q && partial && RMW_ON) ? WRBACK : DONE;
      WRBACK:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, request latch, read data, merge buffer and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      a_rdata  <= 32'h0;
      b_rdata  <= 32'h0;
      last_b_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            port_q  <= grant_b;
            we_q    <= grant_b ? b_we    : a_we;
            waddr_q <= grant_b ? b_addr[ADDR_W-1:2] : a_addr[ADDR_W-1:2];
            be_q    <= grant_b ? b_be    : a_be;
            wdata_q <= grant_b ? b_wdata : a_wdata;
          end
        end
        EXEC: begin
          if (!we_q) begin
            if (port_q) b_rdata <= dm_dout;
            else        a_rdata <= dm_dout;
          end else if (partial && RMW_ON) begin
            merge_q <= merge_d;
          end
        end
        DONE:    last_b_q <= port_q;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state, so reset clears them without waiting for an edge.
  assign busy    = (state_q != IDLE);
  assign a_ack   = (state_q == DONE) && !port_q;
  assign b_ack   = (state_q == DONE) &&  port_q;
  assign dm_addr = waddr_q;
  assign dm_din  = (state_q == WRBACK) ? merge_q : wdata_q;
  assign dm_wen  = ((state_q == EXEC) && we_q && (be_q == 4'hF)) || (state_q == WRBACK);

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural word memory behind it.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [11:0] a_addr = '0, b_addr = '0;
  logic [3:0]  a_be = '0, b_be = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, busy, dm_wen;
  logic [31:0] a_rdata, b_rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;

  logic [31:0] mem [1024];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    bit          port;
    bit          rd;
    logic [31:0] rdata;
    int          lat;
    int          nwen;
    logic [9:0]  waddr;
    logic [31:0] wdin;
  } exp_t;
  exp_t sb[$];

  dm_arbiter #(.ADDR_W(12), .RMW_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .dm_addr(dm_addr), .dm_din(dm_din), .dm_wen(dm_wen), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dm_4k stand-in: asynchronous read, write on the rising edge.
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) if (dm_wen) mem[dm_addr] <= dm_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit port, input bit rd, input logic [31:0] rdata, input int lat,
                      input int nwen, input logic [9:0] waddr, input logic [31:0] wdin);
    exp_t e;
    e.port = port; e.rd = rd; e.rdata = rdata; e.lat = lat;
    e.nwen = nwen; e.waddr = waddr; e.wdin = wdin;
    sb.push_back(e);
  endtask

  // Raise a request on one port, hold it until its ack, then drop it.
  task automatic access(input bit port, input bit we, input logic [11:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata);
    bit got = 0;
    if (port) begin b_we = we; b_addr = addr; b_be = be; b_wdata = wdata; b_req = 1'b1; end
    else      begin a_we = we; a_addr = addr; a_be = be; a_wdata = wdata; a_req = 1'b1; end
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = port ? b_ack : a_ack;
    end
    if (!got) check(port ? "ack_timeout_b" : "ack_timeout_a", 32'd0, 32'd1);
    if (port) b_req = 1'b0; else a_req = 1'b0;
  endtask

  // Monitor: track each occupancy and compare against the scoreboard on every ack.
  bit          busy_prev = 0;
  int          rise_cyc = 0;
  int          nwen_seen = 0;
  logic [9:0]  wen_addr = '0;
  logic [31:0] wen_din = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 0;
    end else begin
      if (busy && !busy_prev) begin
        rise_cyc  = cyc;
        nwen_seen = 0;
      end
      if (dm_wen) begin
        nwen_seen++;
        wen_addr = dm_addr;
        wen_din  = dm_din;
      end
      if (!busy || a_ack || b_ack) check("wen_idle_done", {31'd0, dm_wen}, 32'd0);
      if (a_ack && b_ack) check("dual_ack", 32'd1, 32'd0);
      else if (a_ack || b_ack) begin
        if (sb.size() == 0) check("unexpected_ack", {31'd0, b_ack}, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("grant_port", {31'd0, b_ack}, {31'd0, e.port});
          check("latency", cyc - (rise_cyc - 1), e.lat);
          check("wen_count", nwen_seen, e.nwen);
          if (e.nwen > 0) begin
            check("wen_addr", {22'd0, wen_addr}, {22'd0, e.waddr});
            check("wen_din", wen_din, e.wdin);
          end
          if (e.rd) check(e.port ? "b_rdata" : "a_rdata", e.port ? b_rdata : a_rdata, e.rdata);
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    bit hit;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[10'h040] = 32'h1111_1111;
    mem[10'h041] = 32'h2222_2222;
    mem[10'h008] = 32'h55AA_55AA;

    // Reset held with both requests up.
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h100;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h104;
    repeat (3) @(negedge clk);
    check("rst_a_ack", {31'd0, a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, b_ack}, 32'd0);
    check("rst_dm_wen", {31'd0, dm_wen}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);

    // Contention from reset: A first, then strict alternation.
    push(0, 1, 32'h1111_1111, 2, 0, 10'h0, 32'h0);
    push(1, 1, 32'h2222_2222, 2, 0, 10'h0, 32'h0);
    push(0, 1, 32'h1111_1111, 2, 0, 10'h0, 32'h0);
    push(1, 1, 32'h2222_2222, 2, 0, 10'h0, 32'h0);
    rst_n = 1'b1;
    fork
      begin
        for (int k = 0; k < 2; k++) begin access(0, 0, 12'h100, 4'h0, 32'h0); @(negedge clk); end
      end
      begin
        for (int k = 0; k < 2; k++) begin access(1, 0, 12'h104, 4'h0, 32'h0); @(negedge clk); end
      end
    join
    repeat (2) @(negedge clk);

    // Full write by A, then read back through B.
    push(0, 0, 32'h0, 2, 1, 10'h004, 32'hDEAD_BEEF);
    access(0, 1, 12'h010, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    push(1, 1, 32'hDEAD_BEEF, 2, 0, 10'h0, 32'h0);
    access(1, 0, 12'h010, 4'h0, 32'h0);
    @(negedge clk);
    check("mem_full_write", mem[10'h004], 32'hDEAD_BEEF);

    // Byte-lane RMW on lane 1, then read back through A.
    push(0, 0, 32'h0, 3, 1, 10'h004, 32'hDEAD_ABEF);
    access(0, 1, 12'h011, 4'b0010, 32'h0000_AB00);
    @(negedge clk);
    push(0, 1, 32'hDEAD_ABEF, 2, 0, 10'h0, 32'h0);
    access(0, 0, 12'h010, 4'h0, 32'h0);
    @(negedge clk);
    push(1, 1, 32'h1111_1111, 2, 0, 10'h0, 32'h0);
    access(1, 0, 12'h100, 4'h0, 32'h0);
    @(negedge clk);
    check("a_rdata_held", a_rdata, 32'hDEAD_ABEF);

    // Null write leaves the word alone but still acks.
    push(1, 0, 32'h0, 2, 0, 10'h0, 32'h0);
    access(1, 1, 12'h020, 4'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    check("mem_null_write", mem[10'h008], 32'h55AA_55AA);

    // Top word of the address space; byte offset bits ignored.
    push(1, 0, 32'h0, 2, 1, 10'h3FF, 32'hCAFE_F00D);
    access(1, 1, 12'hFFF, 4'hF, 32'hCAFE_F00D);
    @(negedge clk);
    check("mem_top_word", mem[10'h3FF], 32'hCAFE_F00D);

    // Reset asserted during WRBACK of a partial write.
    a_we = 1'b1; a_addr = 12'h020; a_be = 4'b0001; a_wdata = 32'h0000_00FF; a_req = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = dm_wen;
    end
    check("wrback_reached", {31'd0, hit}, 32'd1);
    check("wrback_din", dm_din, 32'h55AA_55FF);
    #1 rst_n = 1'b0;
    #1;
    check("abort_dm_wen", {31'd0, dm_wen}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_a_ack", {31'd0, a_ack}, 32'd0);
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_mem", mem[10'h008], 32'h55AA_55AA);
    check("abort_idle", {31'd0, busy}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
